scan_index_gen: RTL and testbench



---
 rtl/scan_index_gen.sv | 107 ++++++++++
 tb/tb_scan_index_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/scan_index_gen.sv
// Select-code generator for the 3-to-8 decoder: steps a 3-bit index up, down,
// ping-pong or hold, either from a prescaler or from a synchronized step button.
module scan_index_gen #(
  parameter int TICK_DIV = 50000000,
  parameter int CW       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       step_btn,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       tick
);

  typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_PING, MODE_HOLD} mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] presc;
  logic          auto_adv;
  logic          sync1, sync2, prev_sync;
  logic          step_edge;
  logic          adv;
  logic [2:0]    idx, nxt_idx;
  dir_e          dir, nxt_dir;
  mode_e         mode_s;

  assign auto_adv  = (presc == LAST);
  assign step_edge = sync2 & ~prev_sync;
  // en picks exactly one advance source, so at most one step per cycle.
  assign adv       = en ? auto_adv : step_edge;
  assign mode_s    = mode_e'(mode);

  // NOTE: every register is cleared by the async reset and updated only with
  // non-blocking assignments, so all flops see pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev_sync <= 1'b0;
    end else begin
      sync1     <= step_btn;
      sync2     <= sync1;
      prev_sync <= sync2;
      // Held at zero while disabled so re-enabling always waits a full period.
      if (!en || auto_adv) presc <= '0;
      else                 presc <= presc + 1'b1;
    end
  end

  // NOTE: defaults are assigned first so no path leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    nxt_idx = idx;
    nxt_dir = dir;
    case (mode_s)
      MODE_UP: begin
        nxt_idx = idx + 3'd1;
        nxt_dir = DIR_UP;
      end
      MODE_DOWN: begin
        nxt_idx = idx - 3'd1;
        nxt_dir = DIR_DOWN;
      end
      MODE_PING: begin
        if (dir == DIR_UP) begin
          if (idx == 3'd7) begin
            nxt_idx = 3'd6;
            nxt_dir = DIR_DOWN;
          end else begin
            nxt_idx = idx + 3'd1;
          end
        end else begin
          if (idx == 3'd0) begin
            nxt_idx = 3'd1;
            nxt_dir = DIR_UP;
          end else begin
            nxt_idx = idx - 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= 3'd0;
      dir  <= DIR_UP;
      tick <= 1'b0;
    end else begin
      tick <= adv & (mode_s != MODE_HOLD);
      if (adv) begin
        idx <= nxt_idx;
        dir <= nxt_dir;
      end
    end
  end

  assign {a, b, c} = idx;

endmodule

// File: tb/tb_scan_index_gen.sv
// Bench for scan_index_gen with TICK_DIV=4: a table of directed rows plus
// hand-written sequences for step button, async reset and enable gaps.
module tb_scan_index_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       step_btn = 1'b0;
  logic       a, b, c, tick;

  int n_vec = 0;
  int n_err = 0;
  int tick_cnt = 0;

  scan_index_gen #(.TICK_DIV(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step_btn(step_btn),
    .a(a), .b(b), .c(c), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;   // pulse reset before applying the row
    logic       en;
    logic [1:0] mode;
    int         cyc;   // clock edges to run before checking
    logic [2:0] idx;
    logic       tick;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges; each call returns at a falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tick) tick_cnt++;
    end
  endtask

  task automatic do_row(input vec_t v, input string name);
    if (v.rst) begin
      rst_n = 1'b0;
      run(1);
    end
    en    = v.en;
    mode  = v.mode;
    rst_n = 1'b1;
    run(v.cyc);
    check({name, ".idx"}, int'({a, b, c}), int'(v.idx));
    check({name, ".tick"}, int'(tick), int'(v.tick));
  endtask

  initial begin
    // up count from reset
    tbl.push_back('{1'b1, 1'b1, 2'd0, 3, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 1, 3'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 1, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 3, 3'd2, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 4, 3'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 4, 3'd4, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 4, 3'd5, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 4, 3'd6, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 4, 3'd7, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 4, 3'd0, 1'b1});
    // down from 0 wraps to 7
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4, 3'd7, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4, 3'd6, 1'b1});
    // ping-pong from reset: 1..7, 6..0, 1
    tbl.push_back('{1'b1, 1'b1, 2'd2, 4, 3'd1, 1'b1});
    for (int k = 2; k <= 7; k++) tbl.push_back('{1'b0, 1'b1, 2'd2, 4, 3'(k), 1'b1});
    for (int k = 6; k >= 0; k--) tbl.push_back('{1'b0, 1'b1, 2'd2, 4, 3'(k), 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4, 3'd1, 1'b1});
    // hold, then ping-pong resumes upward
    tbl.push_back('{1'b0, 1'b1, 2'd3, 4, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4, 3'd2, 1'b1});
    for (int k = 3; k <= 7; k++) tbl.push_back('{1'b0, 1'b1, 2'd2, 4, 3'(k), 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4, 3'd6, 1'b1});
    // hold, then ping-pong resumes downward
    tbl.push_back('{1'b0, 1'b1, 2'd3, 4, 3'd6, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4, 3'd5, 1'b1});

    #1 rst_n = 1'b0;
    #1;
    check("reset.idx", int'({a, b, c}), 0);
    check("reset.tick", int'(tick), 0);
    @(negedge clk);

    foreach (tbl[i]) do_row(tbl[i], $sformatf("row%0d", i));

    // single-step button: 3-wide and 10-wide pulses, then hold mode
    do_row('{1'b1, 1'b1, 2'd0, 12, 3'd3, 1'b1}, "step_setup");
    en = 1'b0;
    run(2);
    check("step.pre", int'({a, b, c}), 3);
    tick_cnt = 0;
    step_btn = 1'b1;
    run(2);
    check("step.lat1", int'({a, b, c}), 3);
    run(1);
    check("step.lat2", int'({a, b, c}), 4);
    check("step.tick", int'(tick), 1);
    step_btn = 1'b0;
    run(6);
    check("step.after3", int'({a, b, c}), 4);
    check("step.ticks3", tick_cnt, 1);
    tick_cnt = 0;
    step_btn = 1'b1;
    run(3);
    check("step.long", int'({a, b, c}), 5);
    run(7);
    step_btn = 1'b0;
    run(5);
    check("step.after10", int'({a, b, c}), 5);
    check("step.ticks10", tick_cnt, 1);
    mode = 2'd3;
    tick_cnt = 0;
    step_btn = 1'b1;
    run(3);
    step_btn = 1'b0;
    run(5);
    check("step.hold", int'({a, b, c}), 5);
    check("step.hold_ticks", tick_cnt, 0);

    // async reset while tick is high, then at prescaler=2
    do_row('{1'b1, 1'b1, 2'd0, 4, 3'd1, 1'b1}, "arst_tick_setup");
    #2 rst_n = 1'b0;
    #1;
    check("arst.tick_clr", int'(tick), 0);
    check("arst.idx_clr1", int'({a, b, c}), 0);
    do_row('{1'b0, 1'b1, 2'd0, 6, 3'd1, 1'b0}, "arst_setup");
    #2 rst_n = 1'b0;
    #1;
    check("arst.idx", int'({a, b, c}), 0);
    check("arst.tick", int'(tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3);
    check("arst.wait", int'({a, b, c}), 0);
    run(1);
    check("arst.step", int'({a, b, c}), 1);
    check("arst.step_tick", int'(tick), 1);

    // en dropped at prescaler=2, re-raised; button ignored while en=1
    run(2);
    en = 1'b0;
    tick_cnt = 0;
    run(5);
    check("en.off", int'({a, b, c}), 1);
    check("en.off_ticks", tick_cnt, 0);
    en = 1'b1;
    run(3);
    check("en.reraise_wait", int'({a, b, c}), 1);
    run(1);
    check("en.reraise_step", int'({a, b, c}), 2);
    tick_cnt = 0;
    step_btn = 1'b1;
    run(3);
    check("en.btn_ignored", int'({a, b, c}), 2);
    run(1);
    check("en.btn_next", int'({a, b, c}), 3);
    step_btn = 1'b0;
    check("en.btn_ticks", tick_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
